cgol_display: RTL and testbench
===============================

Name: cgol_display

Overview:
- 8x8 Conway's Game of Life core with an integrated LED-matrix scan driver.
- Holds an 8x8 cell framebuffer, which can be written row by row.
- Advances one generation per step pulse, applying the Life rule to all 64 cells in parallel.
- Continuously multiplexes the framebuffer onto an 8x8 LED matrix through one-hot row drive and active-low column drive.

Parameters:
- SCAN_DIV, 1024, clock cycles each display row stays lit. Legal values are 2 or more.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- we  in  1  row write enable.
- addr  in  3  framebuffer row index for writes.
- bit_in  in  8  row data; bit c is cell (addr, c).
- step  in  1  single-cycle pulse that advances one generation.
- row  out  8  one-hot, active-high row select.
- col  out  8  active-low column drive; col[c]=0 lights cell (scan_row, c).

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - framebuffer, scan_row and scan_cnt go to 0.
  - row=8'h00, col=8'hFF (blank).
  - Reset asserted mid-scan or mid-step takes effect at that edge; any pending write or step is discarded.
- Framebuffer: fb[r][c], r,c in 0..7. Column c maps to bit c of bit_in and col.
- Write: when we=1 at an edge, fb[addr] <= bit_in.
- Life rule, per cell:
  - n = number of live neighbours among the 8 surrounding cells.
  - next = (n==3) | (center & n==2).
  - Cells outside the grid count as dead; there is no toroidal wrap.
- Step: when step=1 at an edge, all 64 cells load their rule result, computed from the pre-edge framebuffer.
- Step held high: one generation per cycle.
- we and step in the same cycle: row addr takes bit_in; every other row takes its stepped value.
- Scan counters:
  - scan_cnt counts 0..SCAN_DIV-1.
  - On wrap, scan_cnt returns to 0 and scan_row increments modulo 8 (7 -> 0).
- Outputs, registered each cycle:
  - row <= 1 << scan_row.
  - col <= ~fb[scan_row].
- Timing:
  - First edge after reset release: row=8'h01.
  - A write or step becomes visible on col two edges later, provided that row is being scanned.
  - row stays one-hot at all times outside reset. Row changes and the matching col update land on the same edge.
- No handshake. Inputs are sampled every edge. we, step and reset act only on the edge where they are sampled.

Decomposition:
- cgol_pkg holds:
  - GRID = 8.
  - typedef row_t = logic [7:0].
  - typedef idx_t = logic [2:0].
  - typedef grid_t = row_t [7:0].
- Sub-module cgol_cell_rule (purely combinational):
  - Ports: center (1), sides[7:0], next_on.
  - next_on = (popcount(sides)==3) | (center & popcount(sides)==2).
  - sides ordering is irrelevant.
  - cgol_display instantiates 64 of these, tying off-grid neighbours to 0.
- Scan counter and output registers stay in the top module.

Test Plan:
- Rule, exhaustive: drive cgol_cell_rule with all 512 {center, sides} combinations against a 10-bit vector file {center, sides[7:0], next_on}.
  - center=0, sides=8'b00000111 -> 1.
  - center=1, sides=8'b00000011 -> 1.
  - center=1, sides=8'b00001111 -> 0.
  - center=0, sides=8'b00000011 -> 0.
- Blinker:
  - Write fb[3]=8'b00011100, all other rows 0, then pulse step.
  - Expect rows 2, 3 and 4 = 8'b00001000.
  - A second step restores the original pattern.
- Still life and corner: block at rows 0-1, 8'b00000011, survives 5 steps unchanged. A lone corner cell dies after one step; nothing appears on row 7 or column 7.
- Scan, SCAN_DIV=4:
  - After reset release, row walks 01, 02, 04, ... 80, 01, holding 4 cycles each.
  - While row=8'h04, col equals ~fb[2] (e.g. fb[2]=8'hA5 -> col=8'h5A).
- Write plus step collision: we=1, addr=3, bit_in=8'hFF, together with step=1 on the blinker pattern. Row 3 becomes 8'hFF; rows 2 and 4 become 8'b00001000.
- Reset mid-operation: assert reset while row=8'h10 on a non-empty grid.
  - Next edge: row=8'h00, col=8'hFF, framebuffer all zero.
  - After release: row=8'h01, col=8'hFF.

Source files
------------

// File: rtl/cgol_pkg.sv
// -----------------------------------------------------------------------------
// cgol_pkg
// Shared types and helpers for the 8x8 Game of Life display core.
//   GRID        : side length of the cell grid
//   row_t       : one framebuffer row, bit c is column c
//   idx_t       : row / column index
//   grid_t      : whole framebuffer, grid_t[r][c]
//   popcount8   : number of set bits in a row_t (0..8)
//   onehot_row  : one-hot row select for a given row index
// -----------------------------------------------------------------------------
package cgol_pkg;

   localparam int GRID = 8;

   typedef logic [7:0] row_t;
   typedef logic [2:0] idx_t;
   typedef row_t [7:0] grid_t;

   function automatic logic [3:0] popcount8(input row_t v);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int b = 0; b < GRID; b++) begin
         cnt = cnt + {3'd0, v[b]};
      end
      return cnt;
   endfunction

   function automatic row_t onehot_row(input idx_t i);
      return row_t'(8'h01 << i);
   endfunction

endpackage

// File: rtl/cgol_display_if.sv
// -----------------------------------------------------------------------------
// cgol_display_if
// Host-side bus of the Life display core.
//   we, addr, bit_in : row write into the framebuffer
//   step             : single-cycle pulse advancing one generation
//   row              : one-hot active-high LED row select
//   col              : active-low LED column drive
// master = host / LED board side, slave = cgol_display.
// -----------------------------------------------------------------------------
interface cgol_display_if;
   import cgol_pkg::*;

   logic we;
   idx_t addr;
   row_t bit_in;
   logic step;
   row_t row;
   row_t col;

   modport master (
      output we,
      output addr,
      output bit_in,
      output step,
      input  row,
      input  col
   );

   modport slave (
      input  we,
      input  addr,
      input  bit_in,
      input  step,
      output row,
      output col
   );

endinterface

// File: rtl/cgol_cell_rule.sv
// -----------------------------------------------------------------------------
// cgol_cell_rule
// Combinational Life rule for one cell.
//   center  : current state of the cell
//   sides   : its eight neighbours, any order
//   next_on : state of the cell in the next generation
// -----------------------------------------------------------------------------
module cgol_cell_rule
   import cgol_pkg::*;
(
   input  logic center,
   input  row_t sides,
   output logic next_on
);

   logic [3:0] n_s;

   // Birth on exactly three neighbours, survival on two or three.
   always_comb begin
      n_s     = popcount8(sides);
      next_on = (n_s == 4'd3) | (center & (n_s == 4'd2));
   end

endmodule

// File: rtl/cgol_display.sv
// -----------------------------------------------------------------------------
// cgol_display
// 8x8 Game of Life framebuffer with an LED-matrix scan driver.
//   clk    : system clock, rising edge
//   reset  : synchronous active-high reset, overrides every other input
//   bus    : cgol_display_if.slave
//            we/addr/bit_in write a row, step advances one generation,
//            row/col drive the LED matrix (row one-hot, col active-low)
// SCAN_DIV : clock cycles each display row stays lit (>= 2)
// -----------------------------------------------------------------------------
module cgol_display
   import cgol_pkg::*;
#(
   parameter int SCAN_DIV = 1024
)
(
   input  logic           clk,
   input  logic           reset,
   cgol_display_if.slave  bus
);

   localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   grid_t            fb_r;
   grid_t            next_s;
   logic [9:0][9:0]  pad_s;
   logic [CNT_W-1:0] scan_cnt_r;
   idx_t             scan_row_r;
   row_t             row_r;
   row_t             col_r;

   // Framebuffer surrounded by a ring of dead cells, so edge cells see zeros.
   always_comb begin
      pad_s = '0;
      for (int r = 0; r < GRID; r++) begin
         for (int c = 0; c < GRID; c++) begin
            pad_s[r+1][c+1] = fb_r[r][c];
         end
      end
   end

   // One rule evaluator per cell; pad_s[gr+1][gc+1] is the cell itself.
   for (genvar gr = 0; gr < GRID; gr++) begin : g_row
      for (genvar gc = 0; gc < GRID; gc++) begin : g_col
         cgol_cell_rule u_rule (
            .center  (fb_r[gr][gc]),
            .sides   ({pad_s[gr][gc],   pad_s[gr][gc+1],   pad_s[gr][gc+2],
                       pad_s[gr+1][gc],                    pad_s[gr+1][gc+2],
                       pad_s[gr+2][gc], pad_s[gr+2][gc+1], pad_s[gr+2][gc+2]}),
            .next_on (next_s[gr][gc])
         );
      end
   end

   // Framebuffer update: a write to a row beats the step for that row only.
   always_ff @(posedge clk) begin
      if (reset) begin
         fb_r <= '0;
      end else begin
         for (int r = 0; r < GRID; r++) begin
            if (bus.we && (bus.addr == idx_t'(r))) begin
               fb_r[r] <= bus.bit_in;
            end else if (bus.step) begin
               fb_r[r] <= next_s[r];
            end else begin
               fb_r[r] <= fb_r[r];
            end
         end
      end
   end

   // Row dwell counter and row pointer; the pointer wraps 7 -> 0 naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_cnt_r <= '0;
         scan_row_r <= 3'd0;
      end else if (scan_cnt_r == CNT_LAST) begin
         scan_cnt_r <= '0;
         scan_row_r <= scan_row_r + 3'd1;
      end else begin
         scan_cnt_r <= scan_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         scan_row_r <= scan_row_r;
      end
   end

   // LED drive: row select and column data come from the same pointer value,
   // so a row change and its column data land on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         row_r <= 8'h00;
         col_r <= 8'hFF;
      end else begin
         row_r <= onehot_row(scan_row_r);
         col_r <= ~fb_r[scan_row_r];
      end
   end

   assign bus.row = row_r;
   assign bus.col = col_r;

endmodule

// File: tb/tb_cgol_display.sv
module tb_cgol_display;
   import cgol_pkg::*;

   localparam int SD = 4;

   typedef struct {
      int   r;
      row_t col;
   } exp_t;

   logic  clk = 1'b0;
   logic  reset;
   int    cmp_cnt = 0;
   int    err_cnt = 0;
   grid_t model;
   exp_t  sb[$];

   logic  rc;
   row_t  rs;
   logic  rn;

   always #5 clk = ~clk;

   cgol_display_if dif ();

   cgol_display #(.SCAN_DIV(SD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dif.slave)
   );

   cgol_cell_rule u_rule (
      .center  (rc),
      .sides   (rs),
      .next_on (rn)
   );

   // Reference Life generation: explicit neighbour walk with bounds checks.
   function automatic grid_t life(input grid_t g);
      grid_t nx;
      int    n;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            n = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if (!(dr == 0 && dc == 0) && (r+dr) >= 0 && (r+dr) < 8 &&
                      (c+dc) >= 0 && (c+dc) < 8) begin
                     if (g[r+dr][c+dc]) n++;
                  end
               end
            end
            nx[r][c] = (n == 3) || (g[r][c] && n == 2);
         end
      end
      return nx;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      cmp_cnt++;
      assert (obs === exp)
      else begin
         err_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int a, input row_t d);
      @(negedge clk);
      dif.we     = 1'b1;
      dif.addr   = idx_t'(a);
      dif.bit_in = d;
      @(negedge clk);
      dif.we     = 1'b0;
      model[a]   = d;
   endtask

   task automatic do_step();
      @(negedge clk);
      dif.step = 1'b1;
      @(negedge clk);
      dif.step = 1'b0;
      model    = life(model);
   endtask

   task automatic clear_fb();
      for (int r = 0; r < 8; r++) wr(r, 8'h00);
   endtask

   // Push every row's expected column drive, then pop as the scan reaches it.
   task automatic check_grid(input string tag);
      exp_t e;
      int   cyc;
      for (int r = 0; r < 8; r++) begin
         e.r   = r;
         e.col = ~model[r];
         sb.push_back(e);
      end
      cyc = 0;
      while (sb.size() > 0 && cyc < SD * 8 * 3) begin
         @(negedge clk);
         cyc++;
         if (dif.row === onehot_row(idx_t'(sb[0].r))) begin
            e = sb.pop_front();
            chk($sformatf("%s.row%0d", tag, e.r), dif.col, e.col);
         end
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         cmp_cnt++;
         err_cnt++;
         $error("FAIL %s.row%0d: scan never reached row, observed row %h expected %h",
                tag, e.r, dif.row, onehot_row(idx_t'(e.r)));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] v;
      int         n;
      int         w;

      dif.we     = 1'b0;
      dif.step   = 1'b0;
      dif.addr   = 3'd0;
      dif.bit_in = 8'h00;
      reset      = 1'b1;
      model      = '0;
      rc         = 1'b0;
      rs         = 8'h00;

      // Cell rule: all 512 input combinations.
      for (int i = 0; i < 512; i++) begin
         v  = 10'(i);
         rc = v[8];
         rs = v[7:0];
         #1;
         n = 0;
         for (int b = 0; b < 8; b++) if (rs[b]) n++;
         chk($sformatf("rule.%03h", i), {7'd0, rn},
             {7'd0, (n == 3) || (rc && n == 2)});
      end
      rc = 1'b0; rs = 8'b00000111; #1; chk("rule.birth3",   {7'd0, rn}, 8'h01);
      rc = 1'b1; rs = 8'b00000011; #1; chk("rule.survive2", {7'd0, rn}, 8'h01);
      rc = 1'b1; rs = 8'b00001111; #1; chk("rule.crowd4",   {7'd0, rn}, 8'h00);
      rc = 1'b0; rs = 8'b00000011; #1; chk("rule.nobirth2", {7'd0, rn}, 8'h00);

      // Reset state.
      repeat (3) @(negedge clk);
      chk("reset.row", dif.row, 8'h00);
      chk("reset.col", dif.col, 8'hFF);

      // Scan walk after release: each row held SD cycles.
      reset = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         chk($sformatf("scan.k%0d", k), dif.row, row_t'(8'h01 << ((k / SD) % 8)));
      end

      // Column drive for a scanned row.
      wr(2, 8'hA5);
      check_grid("col_a5");

      // Blinker oscillates with period two.
      clear_fb();
      wr(3, 8'b00011100);
      check_grid("blinker.g0");
      do_step();
      check_grid("blinker.g1");
      do_step();
      check_grid("blinker.g2");

      // Write and step together.
      @(negedge clk);
      dif.we     = 1'b1;
      dif.addr   = 3'd3;
      dif.bit_in = 8'hFF;
      dif.step   = 1'b1;
      @(negedge clk);
      dif.we     = 1'b0;
      dif.step   = 1'b0;
      model      = life(model);
      model[3]   = 8'hFF;
      check_grid("collide");

      // Block still life plus a lone corner cell.
      clear_fb();
      wr(0, 8'b00000011);
      wr(1, 8'b00000011);
      wr(7, 8'h80);
      check_grid("block.g0");
      for (int s = 1; s <= 5; s++) begin
         do_step();
         check_grid($sformatf("block.g%0d", s));
      end

      // Reset in the middle of a scan on a non-empty grid.
      wr(4, 8'h3C);
      w = 0;
      while (dif.row !== 8'h10 && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("midreset.wait_row10", dif.row, 8'h10);
      dif.we     = 1'b1;
      dif.addr   = 3'd5;
      dif.bit_in = 8'hFF;
      dif.step   = 1'b1;
      reset      = 1'b1;
      @(negedge clk);
      dif.we     = 1'b0;
      dif.step   = 1'b0;
      chk("midreset.row", dif.row, 8'h00);
      chk("midreset.col", dif.col, 8'hFF);
      reset = 1'b0;
      @(negedge clk);
      chk("postreset.row", dif.row, 8'h01);
      chk("postreset.col", dif.col, 8'hFF);
      model = '0;
      check_grid("postreset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
